power_ctrl: RTL and testbench

Power sequencer for the range-hood controller. Owns `machine_state`, the enable input of the mode state machine, and drives it from two sources:
- the power button: short press turns the hood on, long press turns it off;
- the left/right gesture pulses: left-then-right turns it on, right-then-left turns it off, within a timed window.

It sits between the debounced button/gesture front end and the mode FSM.

---
 rtl/power_pkg.sv | 18 +
 rtl/power_ctrl_sec_timer.sv | 35 +++
 rtl/power_ctrl.sv | 92 +++++++++
 tb/tb_power_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/power_pkg.sv
// Shared encodings and default timing constants for the power sequencer
// and the mode FSM it feeds.
package power_pkg;

    typedef enum logic [2:0] {
        OFF      = 3'd0,
        ON_HOLD  = 3'd1,
        ON       = 3'd2,
        OFF_HOLD = 3'd3,
        ARM_ON   = 3'd4,
        ARM_OFF  = 3'd5
    } pwr_state_t;

    localparam int DEF_TICK_CYCLES  = 100_000_000;
    localparam int DEF_LONG_PRESS_S = 3;
    localparam int DEF_GESTURE_S    = 5;

endpackage

// File: rtl/power_ctrl_sec_timer.sv
// Cycle prescaler plus 4-bit saturating seconds count; clr beats en.
module sec_timer
    import power_pkg::*;
#(
    parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic       tick,
    output logic [3:0] secs
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    logic [CW-1:0] pre;

    assign tick = en && (pre == CW'(TICK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pre  <= '0;
            secs <= '0;
        end else if (en) begin
            if (tick) begin
                pre  <= '0;
                secs <= (secs == 4'd15) ? secs : secs + 4'd1;
            end else begin
                pre <= pre + CW'(1);
            end
        end
    end

endmodule

// File: rtl/power_ctrl.sv
// Power sequencer: button short/long press and left/right gesture pairs
// drive machine_state, the enable of the mode FSM.
module power_ctrl
    import power_pkg::*;
#(
    parameter int TICK_CYCLES  = DEF_TICK_CYCLES,
    parameter int LONG_PRESS_S = DEF_LONG_PRESS_S,
    parameter int GESTURE_S    = DEF_GESTURE_S
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       power_btn,
    input  logic       gesture_l,
    input  logic       gesture_r,
    output logic       machine_state,
    output logic [2:0] pwr_state,
    output logic [3:0] secs_left
);

    pwr_state_t state, nxt;
    logic       btn_prev, btn_rise, restart;
    logic       tmr_clr, tmr_en, tick;
    logic [3:0] secs;
    logic       long_done, win_done;
    logic       in_arm;

    assign btn_rise = power_btn & ~btn_prev;
    assign in_arm   = (state == ARM_ON) || (state == ARM_OFF);

    // Both limits fire on the last cycle of their span, so the transition
    // edge is exactly N*TICK_CYCLES samples after counting starts.
    assign long_done = tick && (secs == 4'(LONG_PRESS_S - 1));
    assign win_done  = tick && (secs == 4'(GESTURE_S - 1));

    // One timer serves both the long-press count (ON) and the window (ARM_*).
    assign tmr_en  = in_arm || ((state == ON) && power_btn);
    assign tmr_clr = (nxt != state) || restart || ((state == ON) && !power_btn);

    sec_timer #(.TICK_CYCLES(TICK_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (tmr_clr),
        .en   (tmr_en),
        .tick (tick),
        .secs (secs)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OFF;
            btn_prev <= 1'b1;
        end else begin
            state    <= nxt;
            btn_prev <= power_btn;
        end
    end

    always_comb begin
        nxt     = state;
        restart = 1'b0;
        case (state)
            OFF: begin
                if (btn_rise)       nxt = ON_HOLD;
                else if (gesture_l) nxt = ARM_ON;
            end
            ON_HOLD:  if (!power_btn) nxt = ON;
            ON: begin
                if (power_btn && long_done) nxt = OFF_HOLD;
                else if (gesture_r)         nxt = ARM_OFF;
            end
            OFF_HOLD: if (!power_btn) nxt = OFF;
            ARM_ON: begin
                if (btn_rise)       nxt = ON_HOLD;
                else if (gesture_r) nxt = ON;
                else if (gesture_l) restart = 1'b1;
                else if (win_done)  nxt = OFF;
            end
            ARM_OFF: begin
                if (power_btn)      nxt = ON;
                else if (gesture_l) nxt = OFF;
                else if (gesture_r) restart = 1'b1;
                else if (win_done)  nxt = ON;
            end
            default: nxt = OFF;
        endcase
    end

    assign machine_state = (state == ON_HOLD) || (state == ON) || (state == ARM_OFF);
    assign pwr_state     = state;
    assign secs_left     = in_arm ? (4'(GESTURE_S) - secs) : 4'd0;

endmodule

// File: tb/tb_power_ctrl.sv
// Directed bench for power_ctrl with TICK_CYCLES=10, LONG_PRESS_S=3, GESTURE_S=5.
module tb_power_ctrl;

    logic       clk = 1'b0;
    logic       rst, power_btn, gesture_l, gesture_r;
    logic       machine_state;
    logic [2:0] pwr_state;
    logic [3:0] secs_left;

    int n_tests = 0;
    int n_fail  = 0;

    power_ctrl #(.TICK_CYCLES(10), .LONG_PRESS_S(3), .GESTURE_S(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .power_btn     (power_btn),
        .gesture_l     (gesture_l),
        .gesture_r     (gesture_r),
        .machine_state (machine_state),
        .pwr_state     (pwr_state),
        .secs_left     (secs_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, btn, gl, gr;
        logic       ms;
        logic [2:0] ps;
        logic [3:0] sl;
    } vec_t;

    vec_t tv[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic ms, input logic [2:0] ps,
                           input logic [3:0] sl);
        chk({name, ".ms"}, int'(machine_state), int'(ms));
        chk({name, ".ps"}, int'(pwr_state), int'(ps));
        chk({name, ".sl"}, int'(secs_left), int'(sl));
    endtask

    task automatic idle();
        rst = 1'b0; power_btn = 1'b0; gesture_l = 1'b0; gesture_r = 1'b0;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; step(); rst = 1'b0; step();
    endtask

    // Leaves the DUT in ON with the button released.
    task automatic go_on();
        do_reset();
        power_btn = 1'b1; step();
        power_btn = 1'b0; step();
        chk_all("go_on", 1'b1, 3'd2, 4'd0);
    endtask

    task automatic pulse(input logic l, input logic r);
        gesture_l = l; gesture_r = r; step();
        gesture_l = 1'b0; gesture_r = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        //            rst  btn  gl   gr    ms   ps    sl
        tv.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b0,3'd0,4'd0});
        tv.push_back('{1'b1,1'b1,1'b0,1'b0, 1'b0,3'd0,4'd0});
        tv.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b0,3'd0,4'd0}); // held through reset: no act
        tv.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0,4'd0});
        tv.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b1,3'd1,4'd0}); // rise -> ON_HOLD
        tv.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b1,3'd1,4'd0});
        tv.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b1,3'd2,4'd0}); // release -> ON
        tv.push_back('{1'b0,1'b0,1'b0,1'b1, 1'b1,3'd5,4'd5}); // gr -> ARM_OFF
        tv.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b1,3'd2,4'd0}); // btn cancels
        tv.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b1,3'd2,4'd0});
        tv.push_back('{1'b0,1'b0,1'b0,1'b1, 1'b1,3'd5,4'd5});
        tv.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b1,3'd5,4'd5});
        tv.push_back('{1'b1,1'b0,1'b0,1'b0, 1'b0,3'd0,4'd0}); // reset mid-window
        tv.push_back('{1'b0,1'b0,1'b0,1'b1, 1'b0,3'd0,4'd0}); // gr alone ignored
        tv.push_back('{1'b0,1'b0,1'b1,1'b1, 1'b0,3'd4,4'd5}); // l+r together -> ARM_ON
        tv.push_back('{1'b0,1'b0,1'b0,1'b1, 1'b1,3'd2,4'd0}); // gr completes -> ON
        tv.push_back('{1'b1,1'b0,1'b0,1'b0, 1'b0,3'd0,4'd0});
        tv.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b0,3'd0,4'd0});
        tv.push_back('{1'b0,1'b0,1'b1,1'b0, 1'b0,3'd4,4'd5});
        tv.push_back('{1'b0,1'b1,1'b0,1'b0, 1'b1,3'd1,4'd0}); // rise in ARM_ON
        tv.push_back('{1'b0,1'b0,1'b0,1'b0, 1'b1,3'd2,4'd0});

        for (int i = 0; i < tv.size(); i++) begin
            rst = tv[i].rst; power_btn = tv[i].btn;
            gesture_l = tv[i].gl; gesture_r = tv[i].gr;
            step();
            chk_all($sformatf("vec%0d", i), tv[i].ms, tv[i].ps, tv[i].sl);
        end

        // Long press: 29 samples is short, 30 powers off.
        go_on();
        power_btn = 1'b1;
        for (int i = 0; i < 29; i++) step();
        chk_all("hold29", 1'b1, 3'd2, 4'd0);
        power_btn = 1'b0; step();
        chk_all("hold29_rel", 1'b1, 3'd2, 4'd0);
        power_btn = 1'b1;
        for (int i = 0; i < 29; i++) step();
        chk_all("hold30_pre", 1'b1, 3'd2, 4'd0);
        step();
        chk_all("hold30", 1'b0, 3'd3, 4'd0);
        for (int i = 0; i < 5; i++) step();
        chk_all("hold30_still", 1'b0, 3'd3, 4'd0);
        power_btn = 1'b0; step();
        chk_all("hold30_rel", 1'b0, 3'd0, 4'd0);
        step();
        chk_all("no_repower", 1'b0, 3'd0, 4'd0);

        // Gesture on: left, then right 20 cycles into the window.
        do_reset();
        pulse(1'b1, 1'b0);
        chk_all("arm_entry", 1'b0, 3'd4, 4'd5);
        for (int i = 0; i < 20; i++) step();
        chk_all("arm_20", 1'b0, 3'd4, 4'd3);
        pulse(1'b0, 1'b1);
        chk_all("gest_on", 1'b1, 3'd2, 4'd0);

        // Window expiry with countdown.
        do_reset();
        pulse(1'b1, 1'b0);
        for (int i = 1; i < 50; i++) begin
            step();
            chk_all($sformatf("cd%0d", i), 1'b0, 3'd4, 4'(5 - i / 10));
        end
        step();
        chk_all("expire50", 1'b0, 3'd0, 4'd0);

        // Restart at 40 pushes expiry to 90.
        do_reset();
        pulse(1'b1, 1'b0);
        for (int i = 1; i < 40; i++) step();
        pulse(1'b1, 1'b0);
        chk_all("restart40", 1'b0, 3'd4, 4'd5);
        for (int i = 41; i < 90; i++) step();
        chk_all("restart89", 1'b0, 3'd4, 4'd1);
        step();
        chk_all("restart90", 1'b0, 3'd0, 4'd0);

        // ARM_OFF: left on the expiry cycle wins -> OFF.
        go_on();
        pulse(1'b0, 1'b1);
        chk_all("armoff_entry", 1'b1, 3'd5, 4'd5);
        for (int i = 1; i < 50; i++) step();
        pulse(1'b1, 1'b0);
        chk_all("armoff_gl_exp", 1'b0, 3'd0, 4'd0);

        // ARM_OFF expiry alone -> back to ON, machine_state held throughout.
        go_on();
        pulse(1'b0, 1'b1);
        for (int i = 1; i < 50; i++) begin
            step();
            chk($sformatf("armoff_ms%0d", i), int'(machine_state), 1);
        end
        step();
        chk_all("armoff_exp", 1'b1, 3'd2, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
